// File: rtl/multi_ball_hit_controller_pkg.sv
// Shared types and helpers for the multi-ball hit controller.
//   VEL_W_DEFAULT : default signed velocity width
//   vel_t         : signed velocity at the default width
//   state_t       : resolve FSM states
//   side_t        : which wall of an axis a ball touched
//   sat_neg       : width-generic saturating negation
package hit_pkg;

  localparam int VEL_W_DEFAULT = 11;

  typedef logic signed [VEL_W_DEFAULT-1:0] vel_t;

  typedef enum logic {IDLE = 1'b0, RESOLVE = 1'b1} state_t;

  typedef enum logic [1:0] {
    SIDE_NONE = 2'd0,
    SIDE_LOW  = 2'd1,
    SIDE_HIGH = 2'd2
  } side_t;

  // Negate v as a w-bit signed value; the most negative value maps to the
  // most positive one instead of wrapping back onto itself.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v,
                                                 input int w);
    logic signed [31:0] vmin;
    vmin = -(32'sd1 <<< (w - 1));
    if (v == vmin) return -(vmin + 32'sd1);
    return -v;
  endfunction

endpackage

// File: rtl/multi_ball_hit_controller_if.sv
// Result bus of the hit controller: one strobe per resolved ball.
//   resValid     : result strobe
//   resIdx       : ball index of the result
//   resVelX/Y    : new signed velocity
//   resCollision : velocity was changed
// master = controller (drives), slave = ball movement blocks (receive).
interface multi_ball_hit_controller_if #(
  parameter int VEL_W = hit_pkg::VEL_W_DEFAULT
);
  logic                    resValid;
  logic [2:0]              resIdx;
  logic signed [VEL_W-1:0] resVelX;
  logic signed [VEL_W-1:0] resVelY;
  logic                    resCollision;

  modport master (output resValid, resIdx, resVelX, resVelY, resCollision);
  modport slave  (input  resValid, resIdx, resVelX, resVelY, resCollision);
endinterface

// File: rtl/multi_ball_hit_controller_capture.sv
// Per-frame collision event capture with a snapshot double buffer.
//   i_snap         : copy capture set + velocities into snapshot, clear set
//   i_clearPockets : clear the sticky pocketed vector (beats a hole event)
//   i_pixelX/Y, i_ballDR, i_borderDR, i_holeDR : per-pixel draw requests
//   i_velX/Y       : packed live velocities
//   o_pocketed     : sticky "ball in hole"
//   o_sideX/Y, o_pair, o_velX/Y : snapshotted events and velocities
module collision_event_capture import hit_pkg::*; #(
  parameter int NUM_BALLS   = 2,
  parameter int NUM_HOLES   = 6,
  parameter int VEL_W       = VEL_W_DEFAULT,
  parameter int LEFT_EDGE   = 0,
  parameter int RIGHT_EDGE  = 639,
  parameter int TOP_EDGE    = 0,
  parameter int BOTTOM_EDGE = 479
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           i_snap,
  input  logic                           i_clearPockets,
  input  logic [10:0]                    i_pixelX,
  input  logic [10:0]                    i_pixelY,
  input  logic [NUM_BALLS-1:0]           i_ballDR,
  input  logic                           i_borderDR,
  input  logic [NUM_HOLES-1:0]           i_holeDR,
  input  logic [NUM_BALLS*VEL_W-1:0]     i_velX,
  input  logic [NUM_BALLS*VEL_W-1:0]     i_velY,
  output logic [NUM_BALLS-1:0]           o_pocketed,
  output side_t                          o_sideX [NUM_BALLS],
  output side_t                          o_sideY [NUM_BALLS],
  output logic [NUM_BALLS*NUM_BALLS-1:0] o_pair,
  output logic [NUM_BALLS*VEL_W-1:0]     o_velX,
  output logic [NUM_BALLS*VEL_W-1:0]     o_velY
);
  localparam logic [10:0] L_LEFT   = 11'(LEFT_EDGE);
  localparam logic [10:0] L_RIGHT  = 11'(RIGHT_EDGE);
  localparam logic [10:0] L_TOP    = 11'(TOP_EDGE);
  localparam logic [10:0] L_BOTTOM = 11'(BOTTOM_EDGE);

  logic                           w_xLo, w_xHi, w_yLo, w_yHi, w_hole;
  side_t                          w_evX [NUM_BALLS];
  side_t                          w_evY [NUM_BALLS];
  logic [NUM_BALLS*NUM_BALLS-1:0] w_evPair;

  side_t                          r_sideX [NUM_BALLS];
  side_t                          r_sideY [NUM_BALLS];
  logic [NUM_BALLS*NUM_BALLS-1:0] r_pair;
  logic [NUM_BALLS-1:0]           r_pocketed;
  side_t                          r_snapSideX [NUM_BALLS];
  side_t                          r_snapSideY [NUM_BALLS];
  logic [NUM_BALLS*NUM_BALLS-1:0] r_snapPair;
  logic [NUM_BALLS*VEL_W-1:0]     r_snapVelX, r_snapVelY;

  assign w_xLo  = (i_pixelX <= L_LEFT);
  assign w_xHi  = (i_pixelX >= L_RIGHT);
  assign w_yLo  = (i_pixelY <= L_TOP);
  assign w_yHi  = (i_pixelY >= L_BOTTOM);
  assign w_hole = |i_holeDR;

  // Events of this pixel; balls already in a pocket no longer collide.
  // pair bit [i*NUM_BALLS+j] is only used for i<j.
  always_comb begin
    w_evPair = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      w_evX[i] = SIDE_NONE;
      w_evY[i] = SIDE_NONE;
      if (i_ballDR[i] && i_borderDR && !r_pocketed[i]) begin
        if (w_xLo)      w_evX[i] = SIDE_LOW;
        else if (w_xHi) w_evX[i] = SIDE_HIGH;
        if (w_yLo)      w_evY[i] = SIDE_LOW;
        else if (w_yHi) w_evY[i] = SIDE_HIGH;
      end
      for (int j = i + 1; j < NUM_BALLS; j++) begin
        if (i_ballDR[i] && i_ballDR[j] && !r_pocketed[i] && !r_pocketed[j])
          w_evPair[i*NUM_BALLS+j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        r_sideX[i]     <= SIDE_NONE;
        r_sideY[i]     <= SIDE_NONE;
        r_snapSideX[i] <= SIDE_NONE;
        r_snapSideY[i] <= SIDE_NONE;
      end
      r_pair     <= '0;
      r_snapPair <= '0;
      r_pocketed <= '0;
      r_snapVelX <= '0;
      r_snapVelY <= '0;
    end else begin
      // On snapshot the set restarts from this cycle's events only.
      for (int i = 0; i < NUM_BALLS; i++) begin
        if (i_snap || (w_evX[i] != SIDE_NONE)) r_sideX[i] <= w_evX[i];
        if (i_snap || (w_evY[i] != SIDE_NONE)) r_sideY[i] <= w_evY[i];
      end
      r_pair <= (i_snap ? '0 : r_pair) | w_evPair;
      if (i_snap) begin
        for (int i = 0; i < NUM_BALLS; i++) begin
          r_snapSideX[i] <= r_sideX[i];
          r_snapSideY[i] <= r_sideY[i];
        end
        r_snapPair <= r_pair;
        r_snapVelX <= i_velX;
        r_snapVelY <= i_velY;
      end
      if (i_clearPockets) r_pocketed <= '0;
      else                r_pocketed <= r_pocketed | (i_ballDR & {NUM_BALLS{w_hole}});
    end
  end

  assign o_pocketed = r_pocketed;
  assign o_sideX    = r_snapSideX;
  assign o_sideY    = r_snapSideY;
  assign o_pair     = r_snapPair;
  assign o_velX     = r_snapVelX;
  assign o_velY     = r_snapVelY;

endmodule

// File: rtl/multi_ball_hit_controller.sv
// Multi-ball hit controller: captures border/pocket/ball-ball events during
// the frame, snapshots them on startOfFrame and resolves one ball per clock.
//   clk, resetN            : clock, async active-low reset
//   startOfFrame           : snapshot + resolve trigger
//   pixelX/Y, ballDR, borderDR, holeDR : draw requests
//   ballVelX/Y             : packed live velocities
//   clearPockets           : clears pocketed
//   res (master)           : resValid/resIdx/resVelX/resVelY/resCollision
//   pocketed, busy, overrun: status
module multi_ball_hit_controller import hit_pkg::*; #(
  parameter int NUM_BALLS   = 2,
  parameter int NUM_HOLES   = 6,
  parameter int VEL_W       = VEL_W_DEFAULT,
  parameter int LEFT_EDGE   = 0,
  parameter int RIGHT_EDGE  = 639,
  parameter int TOP_EDGE    = 0,
  parameter int BOTTOM_EDGE = 479
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       startOfFrame,
  input  logic [10:0]                pixelX,
  input  logic [10:0]                pixelY,
  input  logic [NUM_BALLS-1:0]       ballDR,
  input  logic                       borderDR,
  input  logic [NUM_HOLES-1:0]       holeDR,
  input  logic [NUM_BALLS*VEL_W-1:0] ballVelX,
  input  logic [NUM_BALLS*VEL_W-1:0] ballVelY,
  input  logic                       clearPockets,
  multi_ball_hit_controller_if.master res,
  output logic [NUM_BALLS-1:0]       pocketed,
  output logic                       busy,
  output logic                       overrun
);
  state_t                         r_state, w_stateNxt;
  logic [2:0]                     r_idx, w_idxNxt;
  logic                           w_snap;

  side_t                          w_snapSideX [NUM_BALLS];
  side_t                          w_snapSideY [NUM_BALLS];
  logic [NUM_BALLS*NUM_BALLS-1:0] w_snapPair;
  logic [NUM_BALLS*VEL_W-1:0]     w_snapVelX, w_snapVelY;
  logic [NUM_BALLS-1:0]           w_pocketed;

  logic signed [VEL_W-1:0]        w_velX, w_velY, w_pairVelX, w_pairVelY, w_newX, w_newY;
  side_t                          w_sideX, w_sideY;
  logic                           w_pock, w_pairHit, w_negX, w_negY, w_coll;

  logic                           r_resValid, r_resColl, r_overrun;
  logic [2:0]                     r_resIdx;
  logic signed [VEL_W-1:0]        r_resVelX, r_resVelY;

  collision_event_capture #(
    .NUM_BALLS(NUM_BALLS), .NUM_HOLES(NUM_HOLES), .VEL_W(VEL_W),
    .LEFT_EDGE(LEFT_EDGE), .RIGHT_EDGE(RIGHT_EDGE),
    .TOP_EDGE(TOP_EDGE), .BOTTOM_EDGE(BOTTOM_EDGE)
  ) u_capture (
    .clk(clk), .resetN(resetN), .i_snap(w_snap), .i_clearPockets(clearPockets),
    .i_pixelX(pixelX), .i_pixelY(pixelY), .i_ballDR(ballDR),
    .i_borderDR(borderDR), .i_holeDR(holeDR),
    .i_velX(ballVelX), .i_velY(ballVelY),
    .o_pocketed(w_pocketed), .o_sideX(w_snapSideX), .o_sideY(w_snapSideY),
    .o_pair(w_snapPair), .o_velX(w_snapVelX), .o_velY(w_snapVelY)
  );

  always_comb begin
    w_stateNxt = r_state;
    w_idxNxt   = r_idx;
    w_snap     = 1'b0;
    case (r_state)
      IDLE: begin
        if (startOfFrame) begin
          w_stateNxt = RESOLVE;
          w_idxNxt   = '0;
          w_snap     = 1'b1;
        end
      end
      RESOLVE: begin
        if (r_idx == 3'(NUM_BALLS - 1)) w_stateNxt = IDLE;
        else                            w_idxNxt   = r_idx + 3'd1;
      end
      default: w_stateNxt = IDLE;
    endcase
  end

  // Select ball r_idx; partner scan runs high to low so the lowest-index
  // partner is the one left standing.
  always_comb begin
    w_velX     = '0;
    w_velY     = '0;
    w_sideX    = SIDE_NONE;
    w_sideY    = SIDE_NONE;
    w_pock     = 1'b0;
    w_pairHit  = 1'b0;
    w_pairVelX = '0;
    w_pairVelY = '0;
    for (int b = 0; b < NUM_BALLS; b++) begin
      if (r_idx == 3'(b)) begin
        w_velX  = w_snapVelX[b*VEL_W +: VEL_W];
        w_velY  = w_snapVelY[b*VEL_W +: VEL_W];
        w_sideX = w_snapSideX[b];
        w_sideY = w_snapSideY[b];
        w_pock  = w_pocketed[b];
        for (int j = NUM_BALLS - 1; j >= 0; j--) begin
          if ((j != b) && w_snapPair[(j < b ? j : b)*NUM_BALLS + (j < b ? b : j)]) begin
            w_pairHit  = 1'b1;
            w_pairVelX = w_snapVelX[j*VEL_W +: VEL_W];
            w_pairVelY = w_snapVelY[j*VEL_W +: VEL_W];
          end
        end
      end
    end
  end

  // A wall only reflects a ball that is moving into it.
  assign w_negX = ((w_sideX == SIDE_LOW)  &&  w_velX[VEL_W-1]) ||
                  ((w_sideX == SIDE_HIGH) && !w_velX[VEL_W-1] && (w_velX != '0));
  assign w_negY = ((w_sideY == SIDE_LOW)  &&  w_velY[VEL_W-1]) ||
                  ((w_sideY == SIDE_HIGH) && !w_velY[VEL_W-1] && (w_velY != '0));

  always_comb begin
    w_newX = w_velX;
    w_newY = w_velY;
    w_coll = 1'b0;
    if (w_pock) begin
      w_newX = '0;
      w_newY = '0;
      w_coll = 1'b1;
    end else if (w_pairHit) begin
      w_newX = w_pairVelX;
      w_newY = w_pairVelY;
      w_coll = 1'b1;
    end else begin
      if (w_negX) w_newX = VEL_W'(sat_neg(32'(w_velX), VEL_W));
      if (w_negY) w_newY = VEL_W'(sat_neg(32'(w_velY), VEL_W));
      w_coll = w_negX | w_negY;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_resValid <= 1'b0;
      r_resIdx   <= '0;
      r_resVelX  <= '0;
      r_resVelY  <= '0;
      r_resColl  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_stateNxt;
      r_idx      <= w_idxNxt;
      r_resValid <= (r_state == RESOLVE);
      if (r_state == RESOLVE) begin
        r_resIdx  <= r_idx;
        r_resVelX <= w_newX;
        r_resVelY <= w_newY;
        r_resColl <= w_coll;
      end
      if (startOfFrame && (r_state == RESOLVE)) r_overrun <= 1'b1;
    end
  end

  assign res.resValid     = r_resValid;
  assign res.resIdx       = r_resIdx;
  assign res.resVelX      = r_resVelX;
  assign res.resVelY      = r_resVelY;
  assign res.resCollision = r_resColl;
  assign pocketed         = w_pocketed;
  assign busy             = (r_state == RESOLVE);
  assign overrun          = r_overrun;

endmodule

// File: tb/tb_multi_ball_hit_controller.sv
// Directed bench for multi_ball_hit_controller (NUM_BALLS=2, VEL_W=11).
module tb_multi_ball_hit_controller;
  import hit_pkg::*;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX, pixelY;
  logic [1:0]  ballDR;
  logic        borderDR;
  logic [5:0]  holeDR;
  logic [21:0] ballVelX, ballVelY;
  logic        clearPockets;
  logic [1:0]  pocketed;
  logic        busy, overrun;

  multi_ball_hit_controller_if #(.VEL_W(11)) rif();

  multi_ball_hit_controller dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .ballDR(ballDR), .borderDR(borderDR),
    .holeDR(holeDR), .ballVelX(ballVelX), .ballVelY(ballVelY),
    .clearPockets(clearPockets), .res(rif), .pocketed(pocketed),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  dr;
    logic        bd;
    logic [5:0]  hole;
    logic [10:0] px, py;
    vel_t        v0x, v0y, v1x, v1y;
    vel_t        e0x, e0y, e1x, e1y;
    logic [1:0]  ec;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];
  vec_t v;

  int n_tests = 0;
  int n_fail  = 0;

  vel_t       gx [2], gy [2];
  logic       gc [2], gv [2];
  logic [2:0] gi [2];
  logic       gbusy, gtail, gidle;
  int         cnt;

  function automatic vec_t mk(string nm, logic [1:0] dr, logic bd, logic [5:0] hole,
                              int px, int py, int v0x, int v0y, int v1x, int v1y,
                              int e0x, int e0y, int e1x, int e1y, logic [1:0] ec);
    vec_t r;
    r.name = nm; r.dr = dr; r.bd = bd; r.hole = hole;
    r.px = 11'(px); r.py = 11'(py);
    r.v0x = vel_t'(v0x); r.v0y = vel_t'(v0y); r.v1x = vel_t'(v1x); r.v1y = vel_t'(v1y);
    r.e0x = vel_t'(e0x); r.e0y = vel_t'(e0y); r.e1x = vel_t'(e1x); r.e1y = vel_t'(e1y);
    r.ec = ec;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge with the frame's inputs already applied.
  task automatic do_frame();
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    ballDR = '0; borderDR = 1'b0; holeDR = '0;
    gbusy = busy;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      gv[k] = rif.resValid; gi[k] = rif.resIdx;
      gx[k] = rif.resVelX;  gy[k] = rif.resVelY; gc[k] = rif.resCollision;
    end
    @(negedge clk);
    gtail = rif.resValid;
    gidle = busy;
  endtask

  task automatic check_frame(input string nm, input int e0x, input int e0y,
                             input int e1x, input int e1y, input logic [1:0] ec);
    int ex [2];
    int ey [2];
    ex[0] = e0x; ey[0] = e0y; ex[1] = e1x; ey[1] = e1y;
    chk({nm, ".busy"}, int'(gbusy), 1);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.b%0d.valid", nm, k), int'(gv[k]), 1);
      chk($sformatf("%s.b%0d.idx", nm, k), int'(gi[k]), k);
      chk($sformatf("%s.b%0d.vx", nm, k), int'(gx[k]), ex[k]);
      chk($sformatf("%s.b%0d.vy", nm, k), int'(gy[k]), ey[k]);
      chk($sformatf("%s.b%0d.coll", nm, k), int'(gc[k]), int'(ec[k]));
    end
    chk({nm, ".valid_after"}, int'(gtail), 0);
    chk({nm, ".busy_after"}, int'(gidle), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //                 name          dr     bd    hole       px   py   v0x v0y  v1x   v1y  e0x e0y e1x  e1y ec
    vecs[0] = mk("border_neg",  2'b10, 1'b1, 6'b000000,   0, 200,  7,  2,   -5,  3,   7,  2,   5,  3, 2'b10);
    vecs[1] = mk("border_away", 2'b10, 1'b1, 6'b000000,   0, 200,  7,  2,    5,  3,   7,  2,   5,  3, 2'b00);
    vecs[2] = mk("ball_ball",   2'b11, 1'b0, 6'b000000, 300, 200,  3,  0,   -2,  1,  -2,  1,   3,  0, 2'b11);
    vecs[3] = mk("sat_left",    2'b10, 1'b1, 6'b000000,   0, 200,  0,  0,-1024,  0,   0,  0,1023,  0, 2'b10);
    vecs[4] = mk("right_wall",  2'b10, 1'b1, 6'b000000, 639, 100,  1,  1,    9,  4,   1,  1,  -9,  4, 2'b10);
    vecs[5] = mk("corner_br",   2'b10, 1'b1, 6'b000000, 639, 479,  0,  0,    6, -3,   0,  0,  -6, -3, 2'b10);
    vecs[6] = mk("top_wall",    2'b01, 1'b1, 6'b000000, 100,   0,  2, -7,    1,  1,   2,  7,   1,  1, 2'b01);
    vecs[7] = mk("pocket",      2'b10, 1'b0, 6'b010000, 300, 200,  3,  3,    4, -2,   3,  3,   0,  0, 2'b10);
    vecs[8] = mk("no_event",    2'b00, 1'b1, 6'b000000,   0,   0,  1,  2,    3,  4,   1,  2,   3,  4, 2'b00);
    vecs[9] = mk("pair_border", 2'b11, 1'b1, 6'b000000,   0, 200, -4,  1,   -6,  2,  -6,  2,  -4,  1, 2'b11);

    resetN = 1'b0; startOfFrame = 1'b0; pixelX = '0; pixelY = '0;
    ballDR = '0; borderDR = 1'b0; holeDR = '0;
    ballVelX = '0; ballVelY = '0; clearPockets = 1'b0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);

    chk("rst.valid", int'(rif.resValid), 0);
    chk("rst.idx", int'(rif.resIdx), 0);
    chk("rst.vx", int'(rif.resVelX), 0);
    chk("rst.vy", int'(rif.resVelY), 0);
    chk("rst.coll", int'(rif.resCollision), 0);
    chk("rst.pocketed", int'(pocketed), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.overrun", int'(overrun), 0);

    for (int n = 0; n < NV; n++) begin
      v = vecs[n];
      clearPockets = 1'b1;
      @(negedge clk);
      clearPockets = 1'b0;
      ballVelX = {v.v1x, v.v0x};
      ballVelY = {v.v1y, v.v0y};
      pixelX = v.px; pixelY = v.py;
      ballDR = v.dr; borderDR = v.bd; holeDR = v.hole;
      @(negedge clk);
      ballDR = '0; borderDR = 1'b0; holeDR = '0;
      do_frame();
      check_frame(v.name, int'(v.e0x), int'(v.e0y), int'(v.e1x), int'(v.e1y), v.ec);
    end

    // Pocket flag: set one cycle after the event, clear beats a hole event.
    clearPockets = 1'b1;
    @(negedge clk);
    clearPockets = 1'b0;
    pixelX = 11'd300; pixelY = 11'd200;
    ballDR = 2'b10; holeDR = 6'b010000;
    @(negedge clk);
    ballDR = '0; holeDR = '0;
    chk("pocket.set", int'(pocketed), 2);
    ballDR = 2'b01; holeDR = 6'b000001; clearPockets = 1'b1;
    @(negedge clk);
    ballDR = '0; holeDR = '0; clearPockets = 1'b0;
    chk("pocket.clear_priority", int'(pocketed), 0);

    // Event on the snapshot edge lands in the next frame, not this one.
    ballVelX = {11'h7FB, 11'd0};  // ball1 vx=-5
    ballVelY = '0;
    pixelX = 11'd0; pixelY = 11'd200;
    ballDR = 2'b10; borderDR = 1'b1;
    do_frame();
    check_frame("snap_same", 0, 0, -5, 0, 2'b00);
    do_frame();
    check_frame("snap_next", 0, 0, 5, 0, 2'b10);

    // startOfFrame held into the resolve: overrun, result count unchanged.
    startOfFrame = 1'b1;
    @(negedge clk);
    @(negedge clk);
    startOfFrame = 1'b0;
    chk("overrun.flag", int'(overrun), 1);
    cnt = int'(rif.resValid);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      cnt += int'(rif.resValid);
    end
    chk("overrun.count", cnt, 2);
    chk("overrun.busy_end", int'(busy), 0);

    // Reset during ball 0's result aborts the resolve.
    ballVelX = {11'd9, 11'd5};
    ballVelY = {11'd1, 11'd2};
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    @(negedge clk);
    chk("abort.valid_before", int'(rif.resValid), 1);
    resetN = 1'b0;
    #1;
    chk("abort.valid", int'(rif.resValid), 0);
    chk("abort.idx", int'(rif.resIdx), 0);
    chk("abort.vx", int'(rif.resVelX), 0);
    chk("abort.vy", int'(rif.resVelY), 0);
    chk("abort.coll", int'(rif.resCollision), 0);
    chk("abort.busy", int'(busy), 0);
    chk("abort.overrun", int'(overrun), 0);
    @(negedge clk);
    resetN = 1'b1;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cnt += int'(rif.resValid);
    end
    chk("abort.no_more_valid", cnt, 0);
    chk("abort.idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_ball_hit_controller.md
# multi_ball_hit_controller

Parametrised successor of the single-white-ball hit controller. It handles NUM_BALLS balls against the table border, the pockets and each other. During the active frame it accumulates collision events from the per-pixel draw requests. At start of frame it snapshots the events and velocities, then resolves one ball per clock into registered velocity updates for the ball movement blocks.

## Interface
Parameters:
- NUM_BALLS, 2, number of balls (2..8); index 0 is the white ball
- NUM_HOLES, 6, number of pocket draw requests
- VEL_W, 11, signed velocity width
- LEFT_EDGE, 0; RIGHT_EDGE, 639; TOP_EDGE, 0; BOTTOM_EDGE, 479: pixel coordinates of the inner border lines

Ports (clk and resetN first):
- clk  in  1  system/pixel clock
- resetN  in  1  reset; **asynchronous, active-low**
- startOfFrame  in  1  one-cycle pulse in vertical blanking
- pixelX, pixelY  in  11 each  current scan coordinate
- ballDR  in  NUM_BALLS  per-ball draw request
- borderDR  in  1  border draw request
- holeDR  in  NUM_HOLES  pocket draw requests
- ballVelX, ballVelY  in  NUM_BALLS*VEL_W each  packed signed velocities; ball i at [i*VEL_W +: VEL_W]
- clearPockets  in  1  clears the pocketed vector
- resValid  out  1  result strobe
- resIdx  out  3  ball index of the current result
- resVelX, resVelY  out  VEL_W each  new velocity
- resCollision  out  1  1 if the velocity was changed
- pocketed  out  NUM_BALLS  sticky "ball in hole"
- busy  out  1  resolve in progress
- overrun  out  1  sticky; startOfFrame arrived while busy

## Operation
- Capture set, cleared on snapshot. Per clock:
  - ballDR[i]&borderDR sets hitX[i] if pixelX<=LEFT_EDGE or pixelX>=RIGHT_EDGE, and sets hitY[i] if pixelY<=TOP_EDGE or pixelY>=BOTTOM_EDGE.
  - ballDR[i]&(|holeDR) sets pocketed[i] immediately.
  - ballDR[i]&ballDR[j], i<j, sets pair[i][j].
- Events for balls already pocketed are ignored.
- Snapshot on startOfFrame while IDLE:
  - Copy hitX/hitY/pair and ballVelX/Y into resolve registers.
  - Clear the capture set in the same edge. A same-cycle new event is written into the cleared set.
- FSM states:
  - IDLE: on startOfFrame, go to RESOLVE with idx=0.
  - RESOLVE: one ball per clock; idx==NUM_BALLS-1 goes to IDLE.
- Resolution for ball k, first match wins:
  1. pocketed[k]: vel=0, resCollision=1.
  2. Any pair involving k: take the snapshotted velocity of the lowest-index partner (equal-mass exchange), resCollision=1.
  3. hitX/hitY: negate the component only if moving into that wall. For X, that means velX<0 with pixel at left, or velX>0 at right; same rule for Y. Record the side at capture. resCollision=1 if any component changed.
  4. Otherwise pass the velocity through, resCollision=0.
- Negation saturates: -(-2^(VEL_W-1)) = 2^(VEL_W-1)-1.
- startOfFrame while busy: dropped, overrun set, capture keeps accumulating.
- clearPockets clears pocketed; it has priority over a same-cycle hole event.

## Timing
- Reset values: all outputs 0; FSM IDLE; capture, resolve and pocketed registers cleared.
- startOfFrame sampled at edge E0. busy is 1 after E0 through after E(N-1).
- Result for ball k is registered at edge E(k+1). resValid is high for exactly NUM_BALLS consecutive cycles, and resIdx increments by 1 each cycle.
- Latency: startOfFrame to first result is 1 cycle; to the last result is NUM_BALLS cycles.
- Reset mid-resolve aborts immediately; no further resValid.
- Capture is 1-cycle registered from DR inputs; no combinational path from inputs to outputs.

## Structure
- Package hit_pkg holds:
  - VEL_W default
  - typedef vel_t (signed [VEL_W-1:0])
  - state enum {IDLE, RESOLVE}
  - side encoding {NONE, LOW, HIGH}
  - sat_neg function
- Sub-module collision_event_capture: per-frame sticky capture plus snapshot double buffer. The top level holds the FSM and the resolve mux.

## Test plan
- Border: ball1 velX=-5 drawn with borderDR at pixelX=0, then startOfFrame → resIdx=1 gives resVelX=5, resCollision=1. Repeat with velX=+5 at the left edge → velX stays 5, resCollision=0.
- Ball-ball: ball0 (3,0) overlaps ball1 (-2,1), then startOfFrame → results (-2,1) and (3,0), both resCollision=1; resValid high exactly 2 cycles.
- Pocket: ballDR[1]&holeDR[4] → pocketed[1]=1 the next cycle; next frame gives ball1 velocity 0. clearPockets → pocketed=0.
- Saturation: velX=-1024 hits the left wall → resVelX=1023.
- Overrun/reset: startOfFrame on the cycle after E0 → overrun=1 and the result count is unchanged. Assert resetN low during ball 0's result → all outputs 0 and FSM IDLE.
